// File: rtl/bin_text_pkg.sv
// Shared definitions for the ASCII text link: character constants, the
// receive FSM state type and the supported-character test used by both
// the transmit mapper and the receive decoder.
package bin_text_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2,
    HUNT = 2'd3
  } rx_state_t;

  // Printable ASCII minus the three codes the link reserves, plus line end.
  function automatic logic is_supported(input logic [7:0] b);
    is_supported = (b == ASCII_CR) ||
                   ((b >= 8'h20) && (b <= 8'h7E) &&
                    (b != 8'h22) && (b != 8'h25) && (b != 8'h5C));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a valid/ready read side. Pointers carry one extra
// wrap bit so full and empty are distinguished without a count register.
// A write while full is accepted only when a read retires the head the same cycle.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty;
  logic             pop;
  logic             wr_ok;

  // Status flags, handshake qualification and head-of-queue view.
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    rd_valid = ~empty;
    pop      = rd_valid & rd_ready;
    wr_ok    = wr_en & (~full | pop);
    rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

  // Pointer update; wrap past DEPTH is the natural binary rollover.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage array; contents are don't-care until written, empty gates the output.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/bin_to_text_rx.sv
// Receive side of the ASCII text link: frame deserialiser, character
// decode, output queue and saturating status counters.
//
//  state | meaning
//  IDLE  | line idle (1), waiting for a start bit (0)
//  DATA  | shifting 8 data bits, MSB first
//  STOP  | expecting stop bit (1); 0 is a framing error
//  HUNT  | after framing error, wait for line to return to 1
module bin_to_text_rx
  import bin_text_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [7:0]       char_out,
  output logic             char_bad,
  output logic             char_valid,
  input  logic             char_ready,
  output logic             frame_err,
  output logic             ovf_err,
  output logic [CNT_W-1:0] char_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  rx_state_t        state, state_nx;
  logic [7:0]       shreg;
  logic [2:0]       bit_cnt;
  logic             shift_en, stop_ok, frame_ev;
  logic [8:0]       dec_word;
  logic             push_pend;
  logic [8:0]       push_word;
  logic             fifo_full, pop, accept, ovf_ev, bad_ev;
  logic [1:0]       err_inc;
  logic [CNT_W:0]   err_sum;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and per-strobe actions; nothing moves without bit_valid.
  always_comb begin
    state_nx = state;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    frame_ev = 1'b0;
    if (bit_valid) begin
      case (state)
        IDLE: if (!bit_in) state_nx = DATA;
        DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nx = STOP;
        end
        STOP: begin
          if (bit_in) begin
            stop_ok  = 1'b1;
            state_nx = IDLE;
          end else begin
            frame_ev = 1'b1;
            state_nx = HUNT;
          end
        end
        HUNT: if (bit_in) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Decode the assembled byte into {bad, text code}.
  always_comb begin
    dec_word = {1'b1, ASCII_SPACE};
    if (shreg == ASCII_CR)     dec_word = {1'b0, ASCII_LF};
    else if (is_supported(shreg)) dec_word = {1'b0, shreg};
  end

  // Shift register, bit counter and the one-cycle push stage after the stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      push_pend <= 1'b0;
      push_word <= '0;
    end else begin
      if (shift_en) begin
        shreg   <= {shreg[6:0], bit_in};
        bit_cnt <= bit_cnt + 3'd1;
      end
      push_pend <= stop_ok;
      if (stop_ok) push_word <= dec_word;
    end
  end

  // Push acceptance and error events for this cycle.
  always_comb begin
    pop     = char_valid & char_ready;
    accept  = push_pend & (~fifo_full | pop);
    ovf_ev  = push_pend & ~accept;
    bad_ev  = accept & push_word[8];
    err_inc = {1'b0, frame_ev} + {1'b0, ovf_ev} + {1'b0, bad_ev};
    err_sum = {1'b0, err_cnt} + (CNT_W+1)'(err_inc);
  end

  // Error pulses and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      ovf_err   <= 1'b0;
      char_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      frame_err <= frame_ev;
      ovf_err   <= ovf_ev;
      if (accept && (char_cnt != '1)) char_cnt <= char_cnt + CNT_W'(1);
      err_cnt <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    end
  end

  sync_fifo #(
    .WIDTH (9),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (accept),
    .wr_data  (push_word),
    .full     (fifo_full),
    .rd_ready (char_ready),
    .rd_valid (char_valid),
    .rd_data  ({char_bad, char_out})
  );

endmodule

// File: tb/tb_bin_to_text_rx.sv
// Directed bench for bin_to_text_rx with a scoreboard of expected characters.
module tb_bin_to_text_rx;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             bit_in = 1'b1;
  logic             bit_valid = 1'b0;
  logic             char_ready = 1'b0;
  logic [7:0]       char_out;
  logic             char_bad;
  logic             char_valid;
  logic             frame_err;
  logic             ovf_err;
  logic [CNT_W-1:0] char_cnt;
  logic [CNT_W-1:0] err_cnt;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int cnt_exp = 0;
  int err_exp = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  always #5 clk = ~clk;

  bin_to_text_rx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .char_out   (char_out),
    .char_bad   (char_bad),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .frame_err  (frame_err),
    .ovf_err    (ovf_err),
    .char_cnt   (char_cnt),
    .err_cnt    (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] b);
    if (b == 8'h0D) return {1'b0, 8'h0A};
    if (b < 8'h20 || b > 8'h7E || b == 8'h22 || b == 8'h25 || b == 8'h5C)
      return {1'b1, 8'h20};
    return {1'b0, b};
  endfunction

  // Scoreboard: compare the head on every handshake, before the edge that retires it.
  always @(negedge clk) begin
    if (!rst && char_valid === 1'b1 && char_ready === 1'b1) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL pop_unexpected observed=0x%0h expected=none", {char_bad, char_out});
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_data", {23'd0, char_bad, char_out}, {23'd0, mon_e});
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic v);
    bit_in = v;
    bit_valid = 1'b1;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    bit_in = 1'b1;
  endtask

  // Returns just after the stop-bit strobe edge.
  task automatic send(input logic [7:0] b, input logic stop_bit, input bit expect_push);
    logic [8:0] m;
    if (expect_push) begin
      m = model(b);
      exp_q.push_back(m);
      cnt_exp++;
      if (m[8]) err_exp++;
    end
    strobe(1'b0);
    gap(3);
    for (int i = 7; i >= 0; i--) begin
      strobe(b[i]);
      gap(3);
    end
    strobe(stop_bit);
  endtask

  task automatic drain();
    char_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (char_valid !== 1'b1) break;
    end
    check("drain_empty", {31'd0, char_valid}, 32'd0);
    check("drain_queue", exp_q.size(), 32'd0);
    char_ready = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, {31'd0, char_valid}, 32'd0);
    check({tag, "_out"}, {24'd0, char_out}, 32'd0);
    check({tag, "_bad"}, {31'd0, char_bad}, 32'd0);
    check({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_oerr"}, {31'd0, ovf_err}, 32'd0);
    check({tag, "_ccnt"}, {16'd0, char_cnt}, 32'd0);
    check({tag, "_ecnt"}, {16'd0, err_cnt}, 32'd0);
  endtask

  int pulses;
  int pops_before;

  initial begin
    // Reset state
    rst = 1'b1;
    gap(3);
    check_zero("reset");
    rst = 1'b0;
    gap(2);

    // 1: single character and push latency
    char_ready = 1'b0;
    send(8'h41, 1'b1, 1);
    @(negedge clk);
    check("t1_valid_n", {31'd0, char_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("t1_valid_n1", {31'd0, char_valid}, 32'd1);
    check("t1_out", {24'd0, char_out}, 32'h41);
    check("t1_bad", {31'd0, char_bad}, 32'd0);
    check("t1_ccnt", {16'd0, char_cnt}, cnt_exp);
    drain();

    // 2: CR mapped to LF, reserved code flagged bad
    char_ready = 1'b1;
    send(8'h0D, 1'b1, 1);
    gap(3);
    send(8'h25, 1'b1, 1);
    gap(4);
    check("t2_ccnt", {16'd0, char_cnt}, cnt_exp);
    check("t2_ecnt", {16'd0, err_cnt}, err_exp);
    check("t2_ecnt_one", {16'd0, err_cnt}, 32'd1);
    drain();

    // 3: framing error, line held low, resync
    send(8'h42, 1'b0, 0);
    err_exp++;
    check("t3_ferr_hi", {31'd0, frame_err}, 32'd1);
    gap(1);
    check("t3_ferr_lo", {31'd0, frame_err}, 32'd0);
    check("t3_no_push", {31'd0, char_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      strobe(1'b0);
      gap(3);
    end
    strobe(1'b1);
    gap(3);
    send(8'h43, 1'b1, 1);
    gap(4);
    check("t3_ccnt", {16'd0, char_cnt}, cnt_exp);
    check("t3_ecnt", {16'd0, err_cnt}, err_exp);
    drain();

    // 4: overflow with sink stalled
    char_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      send(8'h61 + 8'(k), 1'b1, 1);
      gap(2);
    end
    send(8'h61 + 8'(DEPTH), 1'b1, 0);
    err_exp++;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      gap(1);
      if (ovf_err === 1'b1) pulses++;
    end
    check("t4_ovf_pulses", pulses, 32'd1);
    check("t4_ccnt", {16'd0, char_cnt}, cnt_exp);
    check("t4_ecnt", {16'd0, err_cnt}, err_exp);
    check("t4_head_held", {24'd0, char_out}, 32'h61);
    drain();

    // 5: full FIFO, pop coincides with push
    for (int k = 0; k < DEPTH; k++) begin
      send(8'h30 + 8'(k), 1'b1, 1);
      gap(2);
    end
    send(8'h30 + 8'(DEPTH), 1'b1, 1);
    char_ready = 1'b1;
    @(posedge clk);
    #1;
    char_ready = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      gap(1);
      if (ovf_err === 1'b1) pulses++;
    end
    check("t5_no_ovf", pulses, 32'd0);
    check("t5_ccnt", {16'd0, char_cnt}, cnt_exp);
    pops_before = pops;
    drain();
    check("t5_occupancy", pops - pops_before, DEPTH);

    // 6: reset mid-frame, then a fresh frame
    strobe(1'b0);
    gap(3);
    for (int i = 0; i < 4; i++) begin
      strobe(i[0]);
      gap(3);
    end
    rst = 1'b1;
    gap(2);
    check_zero("t6_rst");
    rst = 1'b0;
    exp_q.delete();
    cnt_exp = 0;
    err_exp = 0;
    gap(2);
    send(8'h7A, 1'b1, 1);
    gap(3);
    check("t6_valid", {31'd0, char_valid}, 32'd1);
    check("t6_out", {24'd0, char_out}, 32'h7A);
    check("t6_ccnt", {16'd0, char_cnt}, cnt_exp);
    check("t6_ecnt", {16'd0, err_cnt}, err_exp);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
